// File: rtl/reg_xfer_sequencer_if.sv
// Handshake and strobe bundle between the decode sequencer (master) and the
// register-transfer sequencer (slave) that drives the register unit.
interface reg_xfer_sequencer_if;
    logic       start;
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] ld;
    logic [7:0] sel;
    logic       selM;
    logic       ldXY;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, op, dst, src,
        input  ld, sel, selM, ldXY, busy, done, err
    );

    modport slave (
        input  start, op, dst, src,
        output ld, sel, selM, ldXY, busy, done, err
    );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// Relay-timed register transfer sequencer: converts one MOV8/CLR8/MOV16 request
// into a select-before-load, load, select-hold strobe sequence for the register unit.
module reg_xfer_sequencer #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned LOAD_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_xfer_sequencer_if.slave   xfer
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 ||
            LOAD_CYC  < 1 || LOAD_CYC  > 15 ||
            HOLD_CYC  < 1 || HOLD_CYC  > 15) begin : gBadParams
            $error("reg_xfer_sequencer: SETUP_CYC, LOAD_CYC and HOLD_CYC must be 1..15");
        end
    endgenerate

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] LOAD_LAST  = 4'(LOAD_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_MOV8  = 2'd0,
        KIND_CLR8  = 2'd1,
        KIND_MOV16 = 2'd2
    } kind_t;

    state_t     state, stateNext;
    logic [3:0] cnt, cntNext;
    kind_t      kindL, kindNext;
    logic [2:0] dstL, dstNext;
    logic [2:0] srcL, srcNext;

    logic [7:0] ldR, ldNext;
    logic [7:0] selR, selNext;
    logic       selMR, selMNext;
    logic       ldXYR, ldXYNext;
    logic       busyR, busyNext;
    logic       doneR, doneNext;
    logic       errR, errNext;

    // A relay register cannot drive and load itself, so MOV8 onto itself clears.
    function automatic kind_t decodeKind(input logic [1:0] opIn,
                                         input logic [2:0] srcIn,
                                         input logic [2:0] dstIn);
        kind_t k;
        case (opIn)
            2'b00:   k = (srcIn == dstIn) ? KIND_CLR8 : KIND_MOV8;
            2'b01:   k = KIND_CLR8;
            default: k = KIND_MOV16;
        endcase
        return k;
    endfunction

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        kindNext  = kindL;
        dstNext   = dstL;
        srcNext   = srcL;
        errNext   = 1'b0;

        case (state)
            IDLE: begin
                if (xfer.start) begin
                    if (xfer.op == 2'b11) begin
                        errNext = 1'b1;
                    end else begin
                        stateNext = SETUP;
                        cntNext   = SETUP_LAST;
                        kindNext  = decodeKind(xfer.op, xfer.src, xfer.dst);
                        dstNext   = xfer.dst;
                        srcNext   = xfer.src;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    stateNext = LOAD;
                    cntNext   = LOAD_LAST;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            LOAD: begin
                if (cnt == 4'd0) begin
                    stateNext = HOLD;
                    cntNext   = HOLD_LAST;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    stateNext = DONE;
                    cntNext   = 4'd0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they register in step with it.
    always_comb begin
        ldNext   = 8'h00;
        selNext  = 8'h00;
        selMNext = 1'b0;
        ldXYNext = 1'b0;
        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);

        if (stateNext == SETUP || stateNext == LOAD || stateNext == HOLD) begin
            if (kindNext == KIND_MOV8) begin
                selNext = 8'h01 << srcNext;
            end else if (kindNext == KIND_MOV16) begin
                selMNext = 1'b1;
            end
        end

        if (stateNext == LOAD) begin
            if (kindNext == KIND_MOV16) begin
                ldXYNext = 1'b1;
            end else begin
                ldNext = 8'h01 << dstNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ldR   <= 8'h00;
            selR  <= 8'h00;
            selMR <= 1'b0;
            ldXYR <= 1'b0;
            busyR <= 1'b0;
            doneR <= 1'b0;
            errR  <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            ldR   <= ldNext;
            selR  <= selNext;
            selMR <= selMNext;
            ldXYR <= ldXYNext;
            busyR <= busyNext;
            doneR <= doneNext;
            errR  <= errNext;
        end
    end

    always_ff @(posedge clk) begin
        kindL <= kindNext;
        dstL  <= dstNext;
        srcL  <= srcNext;
    end

    assign xfer.ld   = ldR;
    assign xfer.sel  = selR;
    assign xfer.selM = selMR;
    assign xfer.ldXY = ldXYR;
    assign xfer.busy = busyR;
    assign xfer.done = doneR;
    assign xfer.err  = errR;

    aOneLoad: assert property (@(posedge clk) disable iff (rst)
        $onehot0({ldR, ldXYR}));

    aOneSel: assert property (@(posedge clk) disable iff (rst)
        $onehot0({selR, selMR}));

    aLoadOnlyInLoad: assert property (@(posedge clk) disable iff (rst)
        ((ldR != 8'h00) || ldXYR) |-> (state == LOAD));

    aIdleQuiet: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (ldR == 8'h00 && selR == 8'h00 && !selMR &&
                             !ldXYR && !busyR && !doneR));

endmodule

// File: doc/reg_xfer_sequencer.md
Name: reg_xfer_sequencer

Overview:
- Sequences register-unit transfers for the relay-model datapath.
- Turns a decoded transfer request into timed select and load strobes: MOV8 (8-bit register to register over the data bus), CLR8, and MOV16 (M to XY over the address bus).
- Enforces relay-style timing: the source select settles before the load strobe and is held after it.
- Sits between the instruction decode/sequencer and the register unit, and owns every ld*/sel* strobe of the register unit.

Parameters:
- SETUP_CYC, 2: cycles the source select is asserted before the load strobe rises (1..15).
- LOAD_CYC, 2: width of the load strobe in cycles (1..15).
- HOLD_CYC, 1: cycles the source select stays asserted after the load strobe falls (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  00 MOV8, 01 CLR8, 10 MOV16 (XY<-M), 11 reserved
- dst  in  3  destination: 0 A, 1 B, 2 C, 3 D, 4 M1, 5 M2, 6 X, 7 Y
- src  in  3  source, same encoding as dst
- ld  out  8  one-hot load strobes, bit index per the dst encoding (ldA..ldY)
- sel  out  8  one-hot data-bus select strobes, bit index per the src encoding (selA..selY)
- selM  out  1  drive M1:M2 onto the address bus
- ldXY  out  1  load XY from the address bus
- busy  out  1  high from the accepted start until done inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse when a reserved op is requested

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- All outputs are registered.
- Reset: every output is 0 and the state is IDLE. rst asserted in any state clears all strobes on the next edge and aborts the transfer; no done pulse is produced.
- States: IDLE, SETUP, LOAD, HOLD, DONE. A 4-bit down-counter times each phase.
- Op latch: op, dst and src are captured on the accepting edge. Later input changes have no effect until the next accept.
- IDLE, start=1, op in {00,01,10}:
  - Go to SETUP.
  - Drive the source strobe: sel[src] for MOV8, selM for MOV16, nothing for CLR8.
  - busy goes to 1.
- IDLE, start=1, op=11: err=1 for one cycle; stay in IDLE; busy stays 0.
- SETUP: lasts SETUP_CYC cycles, then go to LOAD.
- LOAD: lasts LOAD_CYC cycles.
  - Destination strobe asserted for the whole phase: ld[dst] for MOV8 and CLR8, ldXY for MOV16.
  - The source strobe stays asserted.
- HOLD: lasts HOLD_CYC cycles. Source strobe only; no load strobe.
- DONE: one cycle with done=1 and busy=1. All strobes are 0. Next state is IDLE.
- Latency: the source strobe is high for exactly SETUP_CYC+LOAD_CYC+HOLD_CYC cycles. done is high exactly SETUP_CYC+LOAD_CYC+HOLD_CYC+1 cycles after the accepting edge (6 with defaults).
- MOV8 with src==dst: executed as CLR8 of dst. No sel is asserted, because a relay register cannot drive and load itself.
- CLR8: the data bus is undriven (reads 0). Same phase timing as MOV8, with sel always 0.
- Start outside IDLE: start during SETUP, LOAD, HOLD or DONE is ignored; there is no queueing and no err. Back-to-back transfers need start in IDLE. Minimum spacing from one accept to the next is SETUP_CYC+LOAD_CYC+HOLD_CYC+2 cycles.
- Invariants (checked by assertion):
  - At most one bit of ld|{ldXY} is high in any cycle.
  - At most one bit of sel|{selM} is high in any cycle.
  - No ld or ldXY is high unless the state is LOAD.
  - In IDLE, every output is 0 except err.
- Parameters: a value of 0 or greater than 15 is an elaboration error.

Test Plan:
- Reset, then start with op=00, dst=1 (B), src=0 (A), default params:
  - sel=0x01 for cycles 1-5.
  - ld=0x02 for cycles 3-4.
  - done at cycle 6; busy high for cycles 1-6.
  - Register B equals the preloaded A value 0x5A.
- op=00, dst=src=3 (D):
  - sel=0 throughout.
  - ld=0x08 for cycles 3-4.
  - D reads 0x00 after done.
- op=10 with M1:M2=0x12:0x34:
  - selM high for cycles 1-5.
  - ldXY high for cycles 3-4.
  - XY reads 0x1234; ld and sel are 0 throughout.
- op=11: err pulses for one cycle; busy, done and all strobes stay 0.
- Start pulsed again at cycle 2 of an active MOV8: ignored; exactly one done.
- rst asserted at cycle 3 of a MOV8: all strobes 0 on the next cycle; no done; a new start after reset completes normally.
- Params SETUP_CYC=1, LOAD_CYC=3, HOLD_CYC=2:
  - Source strobe high for 6 cycles.
  - Load strobe high for cycles 2-4.
  - done at cycle 7.
